eth_tx_scheduler: RTL and testbench

ETH_TX_SCHEDULER -- requirements
Module: eth_tx_scheduler

---
 rtl/eth_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_scheduler.sv
// Ethernet TX frame scheduler: arbitrates ARP/IP requesters and sequences the
// preamble/header/payload/FCS stages with per-stage timeout and inter-frame gap.
// Optional macro ETH_TX_SCHED_RR_EN selects round-robin arbitration (else ARP has fixed priority).
module eth_tx_scheduler #(
    parameter int IFG_CYCLES    = 12,
    parameter int STAGE_TIMEOUT = 1024
) (
    input  logic aclk,
    input  logic areset,
    input  logic arp_req,
    input  logic ip_req,
    output logic arp_grant,
    output logic ip_grant,
    output logic preamble_sfd_tx_start,
    input  logic preamble_sfd_tx_done,
    output logic eth_header_arp_tx_start,
    output logic eth_header_ip_tx_start,
    input  logic eth_header_arp_tx_done,
    input  logic eth_header_ip_tx_done,
    output logic payload_tx_start,
    input  logic payload_tx_done,
    output logic fcs_tx_start,
    input  logic fcs_tx_done,
    output logic tx_busy,
    output logic frame_done,
    output logic tx_error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        PAYLOAD  = 3'd3,
        FCS      = 3'd4,
        IFG      = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(STAGE_TIMEOUT - 1);
    localparam logic [15:0] IFG_LAST     = 16'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    state_t      next_stage;
    logic [15:0] timer_q, timer_d;
    logic        winner_arp_q, winner_arp_d;
    logic        stage_done;
    logic        in_frame;
`ifdef ETH_TX_SCHED_RR_EN
    logic        last_ip_q, last_ip_d;
`endif

    logic arp_grant_q, arp_grant_d;
    logic ip_grant_q, ip_grant_d;
    logic pre_start_q, pre_start_d;
    logic hdr_arp_start_q, hdr_arp_start_d;
    logic hdr_ip_start_q, hdr_ip_start_d;
    logic pay_start_q, pay_start_d;
    logic fcs_start_q, fcs_start_d;
    logic tx_busy_q, tx_busy_d;
    logic frame_done_q, frame_done_d;
    logic tx_error_q, tx_error_d;

    always_comb begin
        state_d      = state_q;
        next_stage   = IDLE;
        timer_d      = timer_q + 16'd1;
        winner_arp_d = winner_arp_q;
        stage_done   = 1'b0;
        frame_done_d = 1'b0;
        tx_error_d   = 1'b0;
`ifdef ETH_TX_SCHED_RR_EN
        last_ip_d    = last_ip_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (arp_req || ip_req) begin
`ifdef ETH_TX_SCHED_RR_EN
                    // On a tie the requester not served last wins.
                    winner_arp_d = (arp_req && ip_req) ? last_ip_q : arp_req;
                    last_ip_d    = ~winner_arp_d;
`else
                    winner_arp_d = arp_req;
`endif
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                stage_done = preamble_sfd_tx_done;
                next_stage = HEADER;
            end
            HEADER: begin
                stage_done = winner_arp_q ? eth_header_arp_tx_done : eth_header_ip_tx_done;
                next_stage = PAYLOAD;
            end
            PAYLOAD: begin
                stage_done = payload_tx_done;
                next_stage = FCS;
            end
            FCS: begin
                stage_done = fcs_tx_done;
                next_stage = IFG;
            end
            IFG: begin
                if (timer_q == IFG_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // A done sampled in the expiry cycle still advances the frame normally.
        if (state_q inside {PREAMBLE, HEADER, PAYLOAD, FCS}) begin
            if (stage_done) begin
                state_d      = next_stage;
                timer_d      = '0;
                frame_done_d = (state_q == FCS);
            end else if (timer_q == TIMEOUT_LAST) begin
                state_d    = IFG;
                timer_d    = '0;
                tx_error_d = 1'b1;
            end
        end

        in_frame        = state_d inside {PREAMBLE, HEADER, PAYLOAD, FCS};
        arp_grant_d     = in_frame && winner_arp_d;
        ip_grant_d      = in_frame && !winner_arp_d;
        pre_start_d     = (state_d == PREAMBLE);
        hdr_arp_start_d = (state_d == HEADER) && winner_arp_d;
        hdr_ip_start_d  = (state_d == HEADER) && !winner_arp_d;
        pay_start_d     = (state_d == PAYLOAD);
        fcs_start_d     = (state_d == FCS);
        tx_busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            winner_arp_q    <= 1'b0;
            arp_grant_q     <= 1'b0;
            ip_grant_q      <= 1'b0;
            pre_start_q     <= 1'b0;
            hdr_arp_start_q <= 1'b0;
            hdr_ip_start_q  <= 1'b0;
            pay_start_q     <= 1'b0;
            fcs_start_q     <= 1'b0;
            tx_busy_q       <= 1'b0;
            frame_done_q    <= 1'b0;
            tx_error_q      <= 1'b0;
`ifdef ETH_TX_SCHED_RR_EN
            last_ip_q       <= 1'b1;
`endif
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            winner_arp_q    <= winner_arp_d;
            arp_grant_q     <= arp_grant_d;
            ip_grant_q      <= ip_grant_d;
            pre_start_q     <= pre_start_d;
            hdr_arp_start_q <= hdr_arp_start_d;
            hdr_ip_start_q  <= hdr_ip_start_d;
            pay_start_q     <= pay_start_d;
            fcs_start_q     <= fcs_start_d;
            tx_busy_q       <= tx_busy_d;
            frame_done_q    <= frame_done_d;
            tx_error_q      <= tx_error_d;
`ifdef ETH_TX_SCHED_RR_EN
            last_ip_q       <= last_ip_d;
`endif
        end
    end

    assign arp_grant               = arp_grant_q;
    assign ip_grant                = ip_grant_q;
    assign preamble_sfd_tx_start   = pre_start_q;
    assign eth_header_arp_tx_start = hdr_arp_start_q;
    assign eth_header_ip_tx_start  = hdr_ip_start_q;
    assign payload_tx_start        = pay_start_q;
    assign fcs_tx_start            = fcs_start_q;
    assign tx_busy                 = tx_busy_q;
    assign frame_done              = frame_done_q;
    assign tx_error                = tx_error_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Scoreboard bench for eth_tx_scheduler: a stage responder answers each start with a
// done after a programmable number of cycles; expected frame outcomes are queued on request.
module tb_eth_tx_scheduler;

    localparam int IFG = 12;
    localparam int TMO = 16;

    logic aclk, areset, arp_req, ip_req;
    logic arp_grant, ip_grant;
    logic preamble_sfd_tx_start, preamble_sfd_tx_done;
    logic eth_header_arp_tx_start, eth_header_ip_tx_start;
    logic eth_header_arp_tx_done, eth_header_ip_tx_done;
    logic payload_tx_start, payload_tx_done;
    logic fcs_tx_start, fcs_tx_done;
    logic tx_busy, frame_done, tx_error;

    eth_tx_scheduler #(.IFG_CYCLES(IFG), .STAGE_TIMEOUT(TMO)) dut (
        .aclk(aclk), .areset(areset), .arp_req(arp_req), .ip_req(ip_req),
        .arp_grant(arp_grant), .ip_grant(ip_grant),
        .preamble_sfd_tx_start(preamble_sfd_tx_start), .preamble_sfd_tx_done(preamble_sfd_tx_done),
        .eth_header_arp_tx_start(eth_header_arp_tx_start), .eth_header_ip_tx_start(eth_header_ip_tx_start),
        .eth_header_arp_tx_done(eth_header_arp_tx_done), .eth_header_ip_tx_done(eth_header_ip_tx_done),
        .payload_tx_start(payload_tx_start), .payload_tx_done(payload_tx_done),
        .fcs_tx_start(fcs_tx_start), .fcs_tx_done(fcs_tx_done),
        .tx_busy(tx_busy), .frame_done(frame_done), .tx_error(tx_error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic arp;
        logic err;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ends = 0;
    int fd_cyc = -1;
    int grants = 0;
    logic b2b = 1'b0;
    logic g_prev = 1'b0;
    int n_grant, n_pre, n_hdr_arp, n_hdr_ip, n_pay, n_fcs, n_fd;
    int dly_pre = 3, dly_hdr = 3, dly_pay = 3, dly_fcs = 3;
    logic wrong_hdr = 1'b0;

    function automatic logic [9:0] outs();
        return {arp_grant, ip_grant, preamble_sfd_tx_start, eth_header_arp_tx_start,
                eth_header_ip_tx_start, payload_tx_start, fcs_tx_start, tx_busy, frame_done, tx_error};
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Advance one clock, observe outputs, then schedule the responder's dones for the next edge.
    task automatic step();
        logic g;
        exp_t e;
        @(posedge aclk);
        #1;
        cyc++;
        preamble_sfd_tx_done   = 1'b0;
        eth_header_arp_tx_done = 1'b0;
        eth_header_ip_tx_done  = 1'b0;
        payload_tx_done        = 1'b0;
        fcs_tx_done            = 1'b0;
        g = arp_grant | ip_grant;
        if (g && !g_prev) begin
            n_grant = 0; n_pre = 0; n_hdr_arp = 0; n_hdr_ip = 0; n_pay = 0; n_fcs = 0; n_fd = 0;
            grants++;
            if (sb.size() > 0) check_vec("grant_arp", 32'(arp_grant), 32'(sb[0].arp));
            if (b2b && fd_cyc >= 0) check_vec("b2b_gap", 32'(cyc - fd_cyc), 32'(IFG + 1));
        end
        g_prev = g;
        if (g) n_grant++;
        if (preamble_sfd_tx_start) n_pre++;
        if (eth_header_arp_tx_start) n_hdr_arp++;
        if (eth_header_ip_tx_start) n_hdr_ip++;
        if (payload_tx_start) n_pay++;
        if (fcs_tx_start) n_fcs++;
        if (frame_done) n_fd++;
        if ((eth_header_arp_tx_start && eth_header_ip_tx_start) || (arp_grant && ip_grant))
            check_vec("exclusive", 32'(1), 32'(0));
        if (frame_done || tx_error) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_vec("outcome_err", 32'(tx_error), 32'(e.err));
            end else begin
                check_vec("unexpected_end", 32'(1), 32'(0));
            end
            ends++;
            fd_cyc = cyc;
        end
        if (preamble_sfd_tx_start && n_pre == dly_pre) preamble_sfd_tx_done = 1'b1;
        if (eth_header_arp_tx_start && n_hdr_arp == dly_hdr) eth_header_arp_tx_done = 1'b1;
        if (eth_header_ip_tx_start && n_hdr_ip == dly_hdr) eth_header_ip_tx_done = 1'b1;
        if (eth_header_ip_tx_start && wrong_hdr && n_hdr_ip == 2) eth_header_arp_tx_done = 1'b1;
        if (eth_header_ip_tx_start && wrong_hdr && n_hdr_ip == 3) payload_tx_done = 1'b1;
        if (payload_tx_start && n_pay == dly_pay) payload_tx_done = 1'b1;
        if (fcs_tx_start && n_fcs == dly_fcs) fcs_tx_done = 1'b1;
    endtask

    task automatic wait_end(input int budget);
        int target;
        int n;
        target = ends + 1;
        n = 0;
        while (ends < target && n < budget) begin
            step();
            n++;
        end
        check_vec("end_seen", 32'(ends >= target), 32'(1));
    endtask

    task automatic measure_ifg();
        int n;
        n = 0;
        while (tx_busy && n < 64) begin
            n++;
            step();
        end
        check_vec("ifg_len", 32'(n), 32'(IFG));
    endtask

    // Single request: push expectation, check 1-cycle req-to-start latency, drop req after grant.
    task automatic request(input logic arp, input logic err);
        sb.push_back('{arp: arp, err: err});
        arp_req = arp;
        ip_req  = !arp;
        step();
        check_vec("lat_start", 32'(preamble_sfd_tx_start), 32'(1));
        arp_req = 1'b0;
        ip_req  = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) step();
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1; arp_req = 1'b0; ip_req = 1'b0;
        preamble_sfd_tx_done = 1'b0; eth_header_arp_tx_done = 1'b0; eth_header_ip_tx_done = 1'b0;
        payload_tx_done = 1'b0; fcs_tx_done = 1'b0;
        n_grant = 0; n_pre = 0; n_hdr_arp = 0; n_hdr_ip = 0; n_pay = 0; n_fcs = 0; n_fd = 0;

        do_reset();
        check_vec("reset_outs", 32'(outs()), 32'(0));

        // Basic ARP frame, all dones 3 cycles after their start.
        request(1'b1, 1'b0);
        check_vec("lat_grant", 32'(arp_grant), 32'(1));
        wait_end(100);
        check_vec("a_frame_done", 32'(frame_done), 32'(1));
        check_vec("a_grant_low", 32'({arp_grant, ip_grant}), 32'(0));
        check_vec("a_grant_cycles", 32'(n_grant), 32'(12));
        check_vec("a_pre", 32'(n_pre), 32'(3));
        check_vec("a_hdr_arp", 32'(n_hdr_arp), 32'(3));
        check_vec("a_hdr_ip", 32'(n_hdr_ip), 32'(0));
        check_vec("a_pay", 32'(n_pay), 32'(3));
        check_vec("a_fcs", 32'(n_fcs), 32'(3));
        measure_ifg();
        check_vec("a_fd_once", 32'(n_fd), 32'(1));
        check_vec("a_idle_outs", 32'(outs()), 32'(0));

        // Both requesters held across four back-to-back frames, from a fresh reset.
        do_reset();
        b2b = 1'b1;
        fd_cyc = -1;
        for (int k = 0; k < 4; k++) begin
`ifdef ETH_TX_SCHED_RR_EN
            sb.push_back('{arp: (k % 2 == 0), err: 1'b0});
`else
            sb.push_back('{arp: 1'b1, err: 1'b0});
`endif
        end
        arp_req = 1'b1;
        ip_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_end(200);
            if (k == 3) begin
                arp_req = 1'b0;
                ip_req  = 1'b0;
            end
        end
        measure_ifg();
        b2b = 1'b0;
        check_vec("b2b_sb_empty", 32'(sb.size()), 32'(0));

        // IP frame: stray ARP-header and payload dones during HEADER must be ignored.
        dly_hdr = 5;
        wrong_hdr = 1'b1;
        request(1'b0, 1'b0);
        check_vec("ip_grant", 32'(ip_grant), 32'(1));
        wait_end(100);
        check_vec("ip_hdr_ip", 32'(n_hdr_ip), 32'(5));
        check_vec("ip_hdr_arp", 32'(n_hdr_arp), 32'(0));
        check_vec("ip_pay", 32'(n_pay), 32'(3));
        measure_ifg();
        dly_hdr = 3;
        wrong_hdr = 1'b0;

        // Payload never completes: timeout after 16 PAYLOAD cycles.
        dly_pay = 0;
        request(1'b1, 1'b1);
        wait_end(100);
        check_vec("to_error", 32'(tx_error), 32'(1));
        check_vec("to_outs", 32'(outs()), 32'(10'b0000000101));
        check_vec("to_pay", 32'(n_pay), 32'(TMO));
        check_vec("to_fcs", 32'(n_fcs), 32'(0));
        measure_ifg();
        check_vec("to_no_fd", 32'(n_fd), 32'(0));

        // Payload done lands exactly on the expiry cycle: done wins.
        dly_pay = TMO;
        request(1'b1, 1'b0);
        wait_end(100);
        check_vec("edge_fd", 32'(frame_done), 32'(1));
        check_vec("edge_pay", 32'(n_pay), 32'(TMO));
        check_vec("edge_fcs", 32'(n_fcs), 32'(3));
        measure_ifg();
        dly_pay = 3;

        // Reset two cycles into HEADER aborts silently; the next frame runs normally.
        dly_hdr = 10;
        request(1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (n_hdr_arp < 2 && n < 50) begin
                step();
                n++;
            end
            check_vec("rst_in_hdr", 32'(n_hdr_arp), 32'(2));
        end
        areset = 1'b1;
        step();
        areset = 1'b0;
        check_vec("rst_abort_outs", 32'(outs()), 32'(0));
        void'(sb.pop_front());
        dly_hdr = 3;
        request(1'b1, 1'b0);
        wait_end(100);
        check_vec("post_rst_fd", 32'(frame_done), 32'(1));
        check_vec("post_rst_hdr", 32'(n_hdr_arp), 32'(3));
        measure_ifg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
